eth_rx_frame_fifo: RTL
======================

# eth_rx_frame_fifo

Store-and-forward frame buffer between the Ethernet MAC RX AXIS output and the `from_rx_axis` stage. Whole frames are accepted from the MAC without backpressure. A frame is released downstream only after its last beat arrives with `tuser` low. Frames flagged bad by the MAC, and frames that overflow the buffer, are discarded and counted, so the downstream stage never sees a partial or bad frame.

## Interface
Parameters:
- `axis_data_width_p`, 64: AXIS data width; keep width is `axis_data_width_p/8`.
- `els_p`, 512: buffer depth in beats; must be a power of 2, ≥ 4.
- `cnt_width_p`, 16: width of each statistics counter.

Ports:
- `clk_i` in 1: single clock.
- `reset_i` in 1: reset, asynchronous and active-high.
- `s_axis_tdata_i` in `axis_data_width_p`: MAC beat data.
- `s_axis_tkeep_i` in `axis_data_width_p/8`: MAC byte enables.
- `s_axis_tvalid_i` in 1: MAC beat valid.
- `s_axis_tready_o` out 1: constant 1; the MAC cannot be stalled.
- `s_axis_tlast_i` in 1: last beat of the frame.
- `s_axis_tuser_i` in 1: bad-frame flag; meaningful only on the `tlast` beat.
- `m_axis_tdata_o` out `axis_data_width_p`: data toward `from_rx_axis`.
- `m_axis_tkeep_o` out `axis_data_width_p/8`: byte enables toward `from_rx_axis`.
- `m_axis_tvalid_o` out 1: output beat valid.
- `m_axis_tready_i` in 1: downstream accept.
- `m_axis_tlast_o` out 1: last beat of the output frame.
- `m_axis_tuser_o` out 1: constant 0.
- `frames_ok_o` out `cnt_width_p`: frames committed.
- `frames_bad_o` out `cnt_width_p`: frames dropped because `tuser` was set on `tlast`.
- `frames_ovf_o` out `cnt_width_p`: frames dropped because the buffer filled.

## Operation
Pointers:
- `wr_ptr_r`, `commit_ptr_r` and `rd_ptr_r` are each `$clog2(els_p)+1` bits.
- Storage index is the pointer's low bits; the MSB is the wrap bit.
- `full` = (`wr_ptr_r` − `rd_ptr_r`) == `els_p`.
- `avail` = `commit_ptr_r` != `rd_ptr_r`.

Write FSM states:
- **WR_ACCEPT**, the state after reset:
  - On a valid beat with `!full`: store {tdata, tkeep, tlast} at `wr_ptr_r` and increment `wr_ptr_r`.
  - If that beat has tlast & !tuser: set `commit_ptr_r` to `wr_ptr_r`+1 and increment `frames_ok`.
  - If that beat has tlast & tuser: set `wr_ptr_r` back to `commit_ptr_r` and increment `frames_bad`.
  - On a valid beat while `full`: set `wr_ptr_r` back to `commit_ptr_r` and increment `frames_ovf`. If the beat has tlast, stay in WR_ACCEPT; otherwise go to WR_DROP.
- **WR_DROP**: discard beats. On a valid tlast beat, go to WR_ACCEPT; no counter changes.

Read side:
- `m_axis_tvalid_o` = `avail`.
- Data, keep and last come from a combinational read of the entry at `rd_ptr_r`.
- `rd_ptr_r` increments on `m_axis_tvalid_o & m_axis_tready_i`.

Counters:
- Each counter wraps modulo 2^`cnt_width_p`.
- At most one counter increments per cycle.

## Timing
Reset values:
- All pointers 0, FSM in WR_ACCEPT, all counters 0.
- `m_axis_tvalid_o` = 0; `s_axis_tready_o` = 1; `m_axis_tuser_o` = 0.
- Reset may assert mid-frame. Any partially written frame is discarded, and frames that were committed but not yet read are lost. After reset, the next input beat is treated as the start of a frame.

Latency:
- A frame whose tlast is written in cycle N has its first beat valid on `m_axis` in cycle N+1.
- Output beats then stream at one per cycle while `m_axis_tready_i` is high.

Handshake rules:
- Once `m_axis_tvalid_o` rises, it stays high and data stays stable until accepted.
- Never deassert valid within a committed frame.

Simultaneous events:
- A read and a write in the same cycle are allowed.
- `full` uses the registered `rd_ptr_r`, so an entry freed by a read in cycle N is writable only from cycle N+1.
- A commit and a read in the same cycle are both honoured.

Boundary cases:
- A frame longer than `els_p` beats is always dropped as overflow.
- A single-beat frame is legal.
- Frames are never forwarded before commit, i.e. no cut-through.

## Structure
- The write-state enum (`e_wr_accept`, `e_wr_drop`) goes in the shared ethernet package, next to the RX/TX state enums.
- Storage is one `bsg_mem_1r1w`:
  - `width_p` = `axis_data_width_p` + `axis_data_width_p/8` + 1.
  - `els_p` = `els_p`.
  - `read_write_same_addr_p` = 0. Same-address conflicts are impossible because the read side never reads uncommitted entries.
- Pointer, commit and counter logic lives in this module.

## Test plan
- Three good frames of 1, 8 and 64 beats, with `m_axis_tready_i` held at 1: all beats appear in order with matching tkeep/tlast; `frames_ok_o`=3; first output beat valid one cycle after each input tlast.
- A 10-beat frame with tuser=1 on tlast, followed by a 4-beat good frame: only the 4-beat frame is output; `frames_bad_o`=1, `frames_ok_o`=1.
- With `els_p`=16 and `m_axis_tready_i`=0, send a 12-beat good frame then a 10-beat frame: the second frame is dropped; `frames_ovf_o`=1. After raising ready, exactly 12 beats are output.
- With `els_p`=16, send a 20-beat frame: dropped; `frames_ovf_o`=1; the FSM stays in WR_DROP until beat 20; the buffer is empty afterwards.
- Random `m_axis_tready_i` toggling (50%) with back-to-back good frames: no beat loss, valid never drops within a frame, and the data stream matches a scoreboard.
- Assert `reset_i` mid-frame, with one committed frame unread: `m_axis_tvalid_o`=0 immediately, counters read 0, and the next complete good frame passes through intact.

Source files
------------

// File: rtl/eth_rx_frame_fifo_pkg.sv
// Shared Ethernet definitions: MAC-side RX/TX state encodings and the
// write-side state of the RX store-and-forward frame buffer.
package eth_rx_frame_fifo_pkg;

  typedef enum logic [1:0] {
    e_rx_idle  = 2'd0,
    e_rx_data  = 2'd1,
    e_rx_error = 2'd2
  } eth_rx_state_e;

  typedef enum logic [1:0] {
    e_tx_idle  = 2'd0,
    e_tx_data  = 2'd1,
    e_tx_pad   = 2'd2,
    e_tx_fcs   = 2'd3
  } eth_tx_state_e;

  typedef enum logic [0:0] {
    e_wr_accept = 1'b0,
    e_wr_drop   = 1'b1
  } eth_wr_state_e;

  // Pointer width for a ring of els entries: index bits plus one wrap bit.
  function automatic int ptr_width(input int els);
    return $clog2(els) + 1;
  endfunction

endpackage

// File: rtl/bsg_mem_1r1w.sv
// One-write, one-read register-array memory with a combinational read port.
module bsg_mem_1r1w #(
  parameter int width_p                = 8,
  parameter int els_p                  = 16,
  parameter int read_write_same_addr_p = 0,
  localparam int addr_width_lp         = (els_p > 1) ? $clog2(els_p) : 1
) (
  input  logic                     w_clk_i,
  input  logic                     w_v_i,
  input  logic [addr_width_lp-1:0] w_addr_i,
  input  logic [width_p-1:0]       w_data_i,
  input  logic                     r_v_i,
  input  logic [addr_width_lp-1:0] r_addr_i,
  output logic [width_p-1:0]       r_data_o
);

  logic [width_p-1:0] mem_q [els_p];

  // Storage write; no reset, contents are only meaningful once written.
  always_ff @(posedge w_clk_i) begin
    if (w_v_i) begin
      mem_q[w_addr_i] <= w_data_i;
    end
  end

  assign r_data_o = mem_q[r_addr_i];

  // Without same-address support a simultaneous read would see stale data.
  if (read_write_same_addr_p == 0) begin : g_no_same_addr
    assert property (@(posedge w_clk_i)
      !(w_v_i && r_v_i && (w_addr_i == r_addr_i)));
  end

endmodule

// File: rtl/eth_rx_frame_fifo.sv
// Store-and-forward RX frame buffer between the MAC AXIS output and the
// from_rx_axis stage. Frames become visible downstream only once their
// last beat has arrived good; bad and overflowing frames are rewound away.
//
// state       | meaning
// e_wr_accept | storing beats of the current frame (or idle between frames)
// e_wr_drop   | frame overflowed; discarding beats up to its tlast
module eth_rx_frame_fifo
  import eth_rx_frame_fifo_pkg::*;
#(
  parameter int axis_data_width_p = 64,
  parameter int els_p             = 512,
  parameter int cnt_width_p       = 16
) (
  input  logic                           clk_i,
  input  logic                           reset_i,
  input  logic [axis_data_width_p-1:0]   s_axis_tdata_i,
  input  logic [axis_data_width_p/8-1:0] s_axis_tkeep_i,
  input  logic                           s_axis_tvalid_i,
  output logic                           s_axis_tready_o,
  input  logic                           s_axis_tlast_i,
  input  logic                           s_axis_tuser_i,
  output logic [axis_data_width_p-1:0]   m_axis_tdata_o,
  output logic [axis_data_width_p/8-1:0] m_axis_tkeep_o,
  output logic                           m_axis_tvalid_o,
  input  logic                           m_axis_tready_i,
  output logic                           m_axis_tlast_o,
  output logic                           m_axis_tuser_o,
  output logic [cnt_width_p-1:0]         frames_ok_o,
  output logic [cnt_width_p-1:0]         frames_bad_o,
  output logic [cnt_width_p-1:0]         frames_ovf_o
);

  localparam int keep_width_lp = axis_data_width_p / 8;
  localparam int addr_width_lp = $clog2(els_p);
  localparam int ptr_width_lp  = ptr_width(els_p);
  localparam int mem_width_lp  = axis_data_width_p + keep_width_lp + 1;

  localparam logic [ptr_width_lp-1:0] els_ptr_lp = ptr_width_lp'(els_p);
  localparam logic [ptr_width_lp-1:0] ptr_one_lp = ptr_width_lp'(1);
  localparam logic [cnt_width_p-1:0]  cnt_one_lp = cnt_width_p'(1);

  eth_wr_state_e state_q, state_d;

  logic [ptr_width_lp-1:0] wr_ptr_q, wr_ptr_d;
  logic [ptr_width_lp-1:0] commit_ptr_q, commit_ptr_d;
  logic [ptr_width_lp-1:0] rd_ptr_q, rd_ptr_d;

  logic [cnt_width_p-1:0] frames_ok_q, frames_ok_d;
  logic [cnt_width_p-1:0] frames_bad_q, frames_bad_d;
  logic [cnt_width_p-1:0] frames_ovf_q, frames_ovf_d;

  logic                    full;
  logic                    avail;
  logic                    mem_w_v;
  logic [mem_width_lp-1:0] mem_w_data;
  logic [mem_width_lp-1:0] mem_r_data;

  // Occupancy includes the uncommitted tail, measured against the
  // registered read pointer so a freed entry is reusable one cycle later.
  assign full  = ((wr_ptr_q - rd_ptr_q) == els_ptr_lp);
  assign avail = (commit_ptr_q != rd_ptr_q);

  assign mem_w_data = {s_axis_tdata_i, s_axis_tkeep_i, s_axis_tlast_i};

  // Write FSM, commit/rewind of the write pointer, counters and read advance.
  always_comb begin
    state_d      = state_q;
    wr_ptr_d     = wr_ptr_q;
    commit_ptr_d = commit_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    frames_ok_d  = frames_ok_q;
    frames_bad_d = frames_bad_q;
    frames_ovf_d = frames_ovf_q;
    mem_w_v      = 1'b0;

    if (avail && m_axis_tready_i) begin
      rd_ptr_d = rd_ptr_q + ptr_one_lp;
    end

    case (state_q)
      e_wr_accept: begin
        if (s_axis_tvalid_i) begin
          if (!full) begin
            mem_w_v  = 1'b1;
            wr_ptr_d = wr_ptr_q + ptr_one_lp;
            if (s_axis_tlast_i) begin
              if (!s_axis_tuser_i) begin
                commit_ptr_d = wr_ptr_q + ptr_one_lp;
                frames_ok_d  = frames_ok_q + cnt_one_lp;
              end else begin
                wr_ptr_d     = commit_ptr_q;
                frames_bad_d = frames_bad_q + cnt_one_lp;
              end
            end
          end else begin
            // No room for this beat: the whole frame is lost.
            wr_ptr_d     = commit_ptr_q;
            frames_ovf_d = frames_ovf_q + cnt_one_lp;
            if (!s_axis_tlast_i) begin
              state_d = e_wr_drop;
            end
          end
        end
      end
      e_wr_drop: begin
        if (s_axis_tvalid_i && s_axis_tlast_i) begin
          state_d = e_wr_accept;
        end
      end
      default: state_d = e_wr_accept;
    endcase
  end

  // State and pointer registers; reset discards everything buffered.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q      <= e_wr_accept;
      wr_ptr_q     <= '0;
      commit_ptr_q <= '0;
      rd_ptr_q     <= '0;
      frames_ok_q  <= '0;
      frames_bad_q <= '0;
      frames_ovf_q <= '0;
    end else begin
      state_q      <= state_d;
      wr_ptr_q     <= wr_ptr_d;
      commit_ptr_q <= commit_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      frames_ok_q  <= frames_ok_d;
      frames_bad_q <= frames_bad_d;
      frames_ovf_q <= frames_ovf_d;
    end
  end

  // The read side only ever addresses committed entries, so it can never
  // collide with the write address.
  bsg_mem_1r1w #(
    .width_p               (mem_width_lp),
    .els_p                 (els_p),
    .read_write_same_addr_p(0)
  ) storage (
    .w_clk_i (clk_i),
    .w_v_i   (mem_w_v),
    .w_addr_i(wr_ptr_q[addr_width_lp-1:0]),
    .w_data_i(mem_w_data),
    .r_v_i   (avail),
    .r_addr_i(rd_ptr_q[addr_width_lp-1:0]),
    .r_data_o(mem_r_data)
  );

  assign m_axis_tvalid_o = avail;
  assign m_axis_tdata_o  = mem_r_data[mem_width_lp-1 -: axis_data_width_p];
  assign m_axis_tkeep_o  = mem_r_data[keep_width_lp:1];
  assign m_axis_tlast_o  = mem_r_data[0];
  assign m_axis_tuser_o  = 1'b0;
  assign s_axis_tready_o = 1'b1;

  assign frames_ok_o  = frames_ok_q;
  assign frames_bad_o = frames_bad_q;
  assign frames_ovf_o = frames_ovf_q;

endmodule
